aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander.sv | 121 ++++++++++++
 tb/tb_aes_key_expander.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule into 11 stored round keys, streamed out by index; AES_KEY_DECRYPT_EN enables 10..0 order
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
module aes_key_expander (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [`AES_BLOCK_SIZE-1:0] Key,
   input  logic                       Key_valid,
   output logic                       Key_ready,
   output logic                       Busy,
   output logic                       Keys_ready,
   input  logic                       Start,
   input  logic                       Encrypt,
   output logic [`AES_BLOCK_SIZE-1:0] Round_key,
   output logic [3:0]                 Rk_index,
   output logic                       Rk_valid,
   input  logic                       Rk_ready,
   output logic                       Rk_last
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE, STREAM} state_t;
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   state_t       state_q, state_d;
   logic [127:0] rk_q [11];
   logic [127:0] rk_d [11];
   logic [3:0]   cnt_q, cnt_d, idx_q, idx_d;
   logic         valid_q, valid_d, enc_q, enc_d, enc_sel;
   logic [127:0] prev;
   logic [31:0]  temp, w0, w1, w2, w3;
   logic [7:0]   rcon;
   // Table byte x sits 8*(255-x) bits above the LSB, and ~x equals 255-x.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction
`ifdef AES_KEY_DECRYPT_EN
   assign enc_sel = Encrypt;
`else
   logic unused_encrypt;
   assign unused_encrypt = Encrypt;
   assign enc_sel = 1'b1;
`endif
   assign rcon = cnt_q == 4'd1 ? 8'h01 : cnt_q == 4'd2 ? 8'h02 : cnt_q == 4'd3 ? 8'h04 :
                 cnt_q == 4'd4 ? 8'h08 : cnt_q == 4'd5 ? 8'h10 : cnt_q == 4'd6 ? 8'h20 :
                 cnt_q == 4'd7 ? 8'h40 : cnt_q == 4'd8 ? 8'h80 : cnt_q == 4'd9 ? 8'h1b : 8'h36;
   assign prev = rk_q[cnt_q - 4'd1];
   assign temp = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rcon, 24'h0};
   assign w0 = prev[127:96] ^ temp;
   assign w1 = prev[95:64] ^ w0;
   assign w2 = prev[63:32] ^ w1;
   assign w3 = prev[31:0] ^ w2;
   assign Key_ready  = state_q == IDLE || state_q == DONE;
   assign Busy       = state_q == EXPAND;
   assign Keys_ready = state_q == DONE;
   assign Rk_valid   = valid_q;
   assign Rk_index   = idx_q;
   assign Round_key  = rk_q[idx_q];
   assign Rk_last    = valid_q && idx_q == (enc_q ? 4'd10 : 4'd0);
   // Next state: key load has priority over Start; one round key per EXPAND cycle; stream steps on each transfer.
   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      enc_d   = enc_q;
      case (state_q)
         IDLE, DONE: begin
            if (Key_valid) begin
               rk_d[0] = Key;
               cnt_d   = 4'd1;
               state_d = EXPAND;
            end else if (state_q == DONE && Start) begin
               enc_d   = enc_sel;
               idx_d   = enc_sel ? 4'd0 : 4'd10;
               valid_d = 1'b1;
               state_d = STREAM;
            end
         end
         EXPAND: begin
            rk_d[cnt_q] = {w0, w1, w2, w3};
            cnt_d       = cnt_q + 4'd1;
            state_d     = cnt_q == 4'd10 ? DONE : EXPAND;
         end
         STREAM: begin
            if (valid_q && Rk_ready) begin
               if (Rk_last) begin
                  valid_d = 1'b0;
                  state_d = DONE;
               end else
                  idx_d = enc_q ? idx_q + 4'd1 : idx_q - 4'd1;
            end
         end
      endcase
   end
   // State registers; reset clears all stored keys so a new load is required.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         enc_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         enc_q   <= enc_d;
      end
   end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed checks of key schedule, stream order, stall, priority and reset abort
module tb_aes_key_expander;
   logic         Clk = 0, Rst_n = 1, Key_valid = 0, Start = 0, Encrypt = 1, Rk_ready = 0;
   logic [127:0] Key = '0;
   logic         Key_ready, Busy, Keys_ready, Rk_valid, Rk_last;
   logic [127:0] Round_key;
   logic [3:0]   Rk_index;
   int           checks = 0, fails = 0;
   logic [127:0] fips [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes_key_expander dut (
      .Clk(Clk), .Rst_n(Rst_n), .Key(Key), .Key_valid(Key_valid), .Key_ready(Key_ready),
      .Busy(Busy), .Keys_ready(Keys_ready), .Start(Start), .Encrypt(Encrypt),
      .Round_key(Round_key), .Rk_index(Rk_index), .Rk_valid(Rk_valid), .Rk_ready(Rk_ready),
      .Rk_last(Rk_last));

   always #5 Clk = ~Clk;

   task automatic load_key(input logic [127:0] k, output int busy_cycles);
      @(negedge Clk); Key = k; Key_valid = 1;
      @(negedge Clk); Key_valid = 0; busy_cycles = 0;
      while (Busy && busy_cycles < 20) begin busy_cycles++; @(negedge Clk); end
   endtask

   task automatic start_stream(input logic enc);
      @(negedge Clk); Start = 1; Encrypt = enc;
      @(negedge Clk); Start = 0;
   endtask

   task automatic test_reset;
      #2 Rst_n = 0;
      #3;
      checks++;
      if ({Key_ready, Busy, Keys_ready, Rk_valid, Rk_last, Rk_index, Round_key} !== {5'b10000, 4'd0, 128'h0}) begin
         fails++; $display("FAIL reset_state: got %h expected %h", {Key_ready, Busy, Keys_ready, Rk_valid, Rk_last, Rk_index, Round_key}, {5'b10000, 4'd0, 128'h0});
      end
      @(negedge Clk); Rst_n = 1;
      start_stream(1);
      checks++;
      if ({Rk_valid, Keys_ready, Key_ready} !== 3'b001) begin
         fails++; $display("FAIL start_in_idle: got %b expected 001", {Rk_valid, Keys_ready, Key_ready});
      end
   endtask

   task automatic test_encrypt;
      int n;
      load_key(fips[0], n);
      checks++;
      if (n != 10 || Keys_ready !== 1'b1) begin
         fails++; $display("FAIL busy_length: got %0d/%b expected 10/1", n, Keys_ready);
      end
      Rk_ready = 1;
      start_stream(1);
      for (int i = 0; i <= 10; i++) begin
         checks++;
         if ({Rk_valid, Rk_index, Rk_last, Round_key} !== {1'b1, 4'(i), i == 10, fips[i]}) begin
            fails++; $display("FAIL enc_key_%0d: got %h expected %h", i, {Rk_valid, Rk_index, Rk_last, Round_key}, {1'b1, 4'(i), i == 10, fips[i]});
         end
         @(negedge Clk);
      end
      checks++;
      if ({Rk_valid, Keys_ready} !== 2'b01) begin
         fails++; $display("FAIL enc_end: got %b expected 01", {Rk_valid, Keys_ready});
      end
   endtask

   task automatic test_stall;
      int n = 0;
      Rk_ready = 1;
      start_stream(1);
      while (Rk_index != 4'd3 && n < 12) begin @(negedge Clk); n++; end
      Rk_ready = 0;
      for (int j = 0; j < 5; j++) begin
         Key_valid = j == 1; Start = j == 1; Key = '0;
         @(negedge Clk);
         checks++;
         if ({Rk_valid, Rk_index, Rk_last, Key_ready, Busy, Round_key} !== {1'b1, 4'd3, 3'b000, fips[3]}) begin
            fails++; $display("FAIL stall_%0d: got %h expected %h", j, {Rk_valid, Rk_index, Rk_last, Key_ready, Busy, Round_key}, {1'b1, 4'd3, 3'b000, fips[3]});
         end
      end
      Key_valid = 0; Start = 0; Rk_ready = 1;
      @(negedge Clk);
      checks++;
      if ({Rk_index, Round_key} !== {4'd4, fips[4]}) begin
         fails++; $display("FAIL stall_step: got %h expected %h", {Rk_index, Round_key}, {4'd4, fips[4]});
      end
      n = 0;
      while (!Rk_last && n < 15) begin @(negedge Clk); n++; end
      @(negedge Clk);
      checks++;
      if ({Rk_valid, Keys_ready, Round_key} !== {2'b01, fips[10]}) begin
         fails++; $display("FAIL stall_end_retain: got %h expected %h", {Rk_valid, Keys_ready, Round_key}, {2'b01, fips[10]});
      end
   endtask

   task automatic test_order;
      int n;
      logic [3:0] ei;
      load_key(K2, n);
      Rk_ready = 1;
      start_stream(0);
      for (int i = 0; i <= 10; i++) begin
`ifdef AES_KEY_DECRYPT_EN
         ei = 4'(10 - i);
`else
         ei = 4'(i);
`endif
         checks++;
         if ({Rk_valid, Rk_index, Rk_last} !== {1'b1, ei, i == 10}) begin
            fails++; $display("FAIL order_%0d: got %h expected %h", i, {Rk_valid, Rk_index, Rk_last}, {1'b1, ei, i == 10});
         end
         if (i == 0 || i == 10) begin
            checks++;
            if (Round_key !== (ei == 4'd10 ? K2_10 : K2)) begin
               fails++; $display("FAIL order_key_%0d: got %h expected %h", i, Round_key, ei == 4'd10 ? K2_10 : K2);
            end
         end
         @(negedge Clk);
      end
      checks++;
      if ({Rk_valid, Keys_ready} !== 2'b01) begin
         fails++; $display("FAIL order_end: got %b expected 01", {Rk_valid, Keys_ready});
      end
   endtask

   task automatic test_key_start_collision;
      int n = 0;
      @(negedge Clk); Key = fips[0]; Key_valid = 1; Start = 1; Encrypt = 1;
      @(negedge Clk); Key_valid = 0;
      checks++;
      if ({Busy, Rk_valid} !== 2'b10) begin
         fails++; $display("FAIL collision_load: got %b expected 10", {Busy, Rk_valid});
      end
      @(negedge Clk); Start = 0;
      while (Busy && n < 20) begin @(negedge Clk); n++; end
      checks++;
      if ({Keys_ready, Rk_valid} !== 2'b10) begin
         fails++; $display("FAIL collision_done: got %b expected 10", {Keys_ready, Rk_valid});
      end
      Rk_ready = 1;
      start_stream(1);
      checks++;
      if (Round_key !== fips[0]) begin
         fails++; $display("FAIL collision_newkey: got %h expected %h", Round_key, fips[0]);
      end
      n = 0;
      while (!Keys_ready && n < 20) begin @(negedge Clk); n++; end
   endtask

   task automatic test_reset_mid_expand;
      @(negedge Clk); Key = K2; Key_valid = 1;
      @(negedge Clk); Key_valid = 0;
      repeat (4) @(negedge Clk);
      #1 Rst_n = 0;
      #1;
      checks++;
      if ({Key_ready, Keys_ready, Busy, Rk_valid, Round_key} !== {4'b1000, 128'h0}) begin
         fails++; $display("FAIL reset_abort: got %h expected %h", {Key_ready, Keys_ready, Busy, Rk_valid, Round_key}, {4'b1000, 128'h0});
      end
      @(negedge Clk); Rst_n = 1;
      start_stream(1);
      checks++;
      if ({Key_ready, Keys_ready, Busy, Rk_valid} !== 4'b1000) begin
         fails++; $display("FAIL reset_start_ignored: got %b expected 1000", {Key_ready, Keys_ready, Busy, Rk_valid});
      end
   endtask

   initial begin
      test_reset;
      test_encrypt;
      test_stall;
      test_order;
      test_key_start_collision;
      test_reset_mid_expand;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
